// File: rtl/ctrl_seq.sv
// Control sequencer for a small accumulator-style processor: fetches 9-bit
// instructions, drives the register file, ALU and data memory, and halts on unknown opcodes.

package ctrl_seq_pkg;
  typedef enum logic [2:0] {
    kLDR = 3'd0,
    kSTR = 3'd1,
    kACC = 3'd2,
    kACI = 3'd3,
    kBZR = 3'd4,
    kBZA = 3'd5
  } op_mne;
endpackage

module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned PCW = 8,
  parameter int unsigned IW  = 9
) (
  input  logic           CLK,
  input  logic           rst_n,
  input  logic           start,
  output logic [PCW-1:0] imem_addr,
  input  logic [IW-1:0]  imem_data,
  output logic [2:0]     rf_ra_a,
  output logic [2:0]     rf_ra_b,
  output logic [2:0]     rf_wa,
  output logic           rf_we,
  output logic           wb_sel,
  output logic [2:0]     alu_op,
  output logic           alu_ci,
  input  logic           alu_co,
  input  logic           alu_z,
  output logic           dmem_req,
  output logic           dmem_we,
  input  logic           dmem_ack,
  output logic           done
);

  localparam int unsigned RW = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    EXEC  = 3'd3,
    MEM   = 3'd4,
    HALT  = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [IW-1:0]  ir_q, ir_d;
  logic           carry_q, carry_d;
  logic [1:0]     rst_sync_q;
  logic           run_ok;

  logic [RW-1:0]  op, ra, rb;
  logic [PCW-1:0] pc_inc, br_off;

  assign op     = ir_q[8:6];
  assign ra     = ir_q[5:3];
  assign rb     = ir_q[2:0];
  assign pc_inc = pc_q + PCW'(1);
  assign br_off = {{(PCW-RW){rb[RW-1]}}, rb};
  assign run_ok = rst_sync_q[1];

  assign imem_addr = pc_q;

  // State, PC, IR, carry and the reset-release synchroniser
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      carry_q    <= 1'b0;
      rst_sync_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      carry_q    <= carry_d;
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    carry_d  = carry_q;
    rf_ra_a  = '0;
    rf_ra_b  = '0;
    rf_wa    = '0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    alu_op   = kLDR;
    alu_ci   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        // Leaving IDLE waits for the synchronised reset release
        if (start && run_ok) begin
          state_d = FETCH;
          pc_d    = '0;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        ir_d    = imem_data;
        state_d = EXEC;
      end
      EXEC: begin
        alu_op  = op;
        rf_ra_a = ra;
        rf_ra_b = rb;
        alu_ci  = carry_q;
        case (op)
          kACC, kACI: begin
            rf_we   = 1'b1;
            rf_wa   = ra;
            carry_d = alu_co;
            pc_d    = pc_inc;
            state_d = FETCH;
          end
          kBZR: begin
            pc_d    = alu_z ? (pc_q + br_off) : pc_inc;
            state_d = FETCH;
          end
          kBZA: begin
            pc_d    = alu_z ? PCW'({rb, 5'b0}) : pc_inc;
            state_d = FETCH;
          end
          kLDR, kSTR: state_d = MEM;
          default:    state_d = HALT;
        endcase
      end
      MEM: begin
        // Request and address sources held until the ack cycle
        alu_op   = op;
        rf_ra_a  = ra;
        rf_ra_b  = rb;
        dmem_req = 1'b1;
        dmem_we  = (op == kSTR);
        if (dmem_ack) begin
          state_d = FETCH;
          pc_d    = pc_inc;
          if (op == kLDR) begin
            rf_we  = 1'b1;
            rf_wa  = ra;
            wb_sel = 1'b1;
          end
        end
      end
      HALT: begin
        done = 1'b1;
        if (start) begin
          state_d = FETCH;
          pc_d    = '0;
          carry_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: behavioural instruction memory, hand-driven ALU flags
// and data-memory acks, immediate-assertion checks at fixed cycle offsets.

module tb_ctrl_seq;

  localparam logic [2:0] K_LDR = 3'd0;
  localparam logic [2:0] K_STR = 3'd1;
  localparam logic [2:0] K_ACC = 3'd2;
  localparam logic [2:0] K_ACI = 3'd3;
  localparam logic [2:0] K_BZR = 3'd4;
  localparam logic [2:0] K_BZA = 3'd5;
  localparam logic [2:0] K_BAD = 3'd7;

  logic       CLK;
  logic       rst_n;
  logic       start;
  logic [7:0] imem_addr;
  logic [8:0] imem_data;
  logic [2:0] rf_ra_a, rf_ra_b, rf_wa, alu_op;
  logic       rf_we, wb_sel, alu_ci, alu_co, alu_z;
  logic       dmem_req, dmem_we, dmem_ack, done;

  logic [8:0] imem [256];
  int total = 0;
  int bad   = 0;

  ctrl_seq #(.PCW(8), .IW(9)) dut (
    .CLK(CLK), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .rf_ra_a(rf_ra_a), .rf_ra_b(rf_ra_b), .rf_wa(rf_wa), .rf_we(rf_we),
    .wb_sel(wb_sel), .alu_op(alu_op), .alu_ci(alu_ci), .alu_co(alu_co),
    .alu_z(alu_z), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory with one cycle of read latency
  always @(posedge CLK) imem_data <= imem[imem_addr];

  function automatic logic [8:0] ins(input logic [2:0] o, input logic [2:0] a,
                                     input logic [2:0] b);
    return {o, a, b};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one non-memory instruction starting from its FETCH cycle
  task automatic run_alu(input string tag, input logic [2:0] e_op, input logic [2:0] e_a,
                         input logic [2:0] e_b, input logic e_we, input logic e_ci,
                         input logic co, input logic z, input logic [7:0] e_next);
    tick();
    chk({tag, "_load_op"}, 8'(alu_op), 8'(K_LDR));
    chk({tag, "_load_we"}, 8'(rf_we), 8'd0);
    alu_co = co;
    alu_z  = z;
    tick();
    chk({tag, "_op"}, 8'(alu_op), 8'(e_op));
    chk({tag, "_ra_a"}, 8'(rf_ra_a), 8'(e_a));
    chk({tag, "_ra_b"}, 8'(rf_ra_b), 8'(e_b));
    chk({tag, "_we"}, 8'(rf_we), 8'(e_we));
    chk({tag, "_ci"}, 8'(alu_ci), 8'(e_ci));
    chk({tag, "_wbsel"}, 8'(wb_sel), 8'd0);
    if (e_we) chk({tag, "_wa"}, 8'(rf_wa), 8'(e_a));
    tick();
    alu_co = 1'b0;
    alu_z  = 1'b0;
    chk({tag, "_next_pc"}, imem_addr, e_next);
    chk({tag, "_fetch_we"}, 8'(rf_we), 8'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    alu_co   = 1'b0;
    alu_z    = 1'b0;
    dmem_ack = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = ins(K_ACI, 3'd7, 3'd7);
    imem[0]   = ins(K_ACC, 3'd1, 3'd2);
    imem[1]   = ins(K_ACC, 3'd3, 3'd0);
    imem[10]  = ins(K_BZR, 3'd4, 3'b110);
    imem[11]  = ins(K_LDR, 3'd5, 3'd6);
    imem[12]  = ins(K_BZA, 3'd0, 3'd7);
    imem[32]  = ins(K_STR, 3'd5, 3'd6);
    imem[255] = ins(K_ACC, 3'd2, 3'd2);

    // Reset values
    repeat (3) tick();
    chk("rst_pc", imem_addr, 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_req", 8'(dmem_req), 8'd0);
    chk("rst_dwe", 8'(dmem_we), 8'd0);
    chk("rst_we", 8'(rf_we), 8'd0);
    chk("rst_wbsel", 8'(wb_sel), 8'd0);
    chk("rst_ci", 8'(alu_ci), 8'd0);
    chk("rst_op", 8'(alu_op), 8'(K_LDR));

    // Release with start held: FETCH is entered on the third edge
    rst_n = 1'b1;
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;

    // ACC chain: first sets carry, second sees it as carry in
    run_alu("acc1", K_ACC, 3'd1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
    run_alu("acc2", K_ACC, 3'd3, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
    for (int pc = 2; pc < 9; pc++)
      run_alu("fill_a", K_ACI, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'(pc + 1));
    run_alu("fill_9", K_ACI, 3'd7, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 8'd10);

    // BZR taken backwards by 2, carry untouched, then not taken
    run_alu("bzr_t", K_BZR, 3'd4, 3'd6, 1'b0, 1'b1, 1'b0, 1'b1, 8'd8);
    run_alu("fill_8b", K_ACI, 3'd7, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 8'd9);
    run_alu("fill_9b", K_ACI, 3'd7, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 8'd10);
    run_alu("bzr_f", K_BZR, 3'd4, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 8'd11);

    // LDR with ack in the fourth MEM cycle; early acks must be ignored
    tick();
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("ldr_ex_op", 8'(alu_op), 8'(K_LDR));
    chk("ldr_ex_ra", 8'(rf_ra_a), 8'd5);
    chk("ldr_ex_req", 8'(dmem_req), 8'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) begin
        dmem_ack = 1'b1;
        #1;
      end
      chk("ldr_req", 8'(dmem_req), 8'd1);
      chk("ldr_dwe", 8'(dmem_we), 8'd0);
      chk("ldr_ra_a", 8'(rf_ra_a), 8'd5);
      chk("ldr_ra_b", 8'(rf_ra_b), 8'd6);
      chk("ldr_we", 8'(rf_we), 8'((k == 4) ? 1 : 0));
      chk("ldr_wbsel", 8'(wb_sel), 8'((k == 4) ? 1 : 0));
    end
    chk("ldr_wa", 8'(rf_wa), 8'd5);
    tick();
    dmem_ack = 1'b0;
    chk("ldr_after_req", 8'(dmem_req), 8'd0);
    chk("ldr_after_we", 8'(rf_we), 8'd0);
    chk("ldr_next_pc", imem_addr, 8'd12);

    // BZA to 224, run up to the wrap with start held (must be ignored)
    run_alu("bza", K_BZA, 3'd0, 3'd7, 1'b0, 1'b1, 1'b0, 1'b1, 8'd224);
    start = 1'b1;
    for (int pc = 224; pc < 255; pc++)
      run_alu("fill_b", K_ACI, 3'd7, 3'd7, 1'b1, 1'((pc == 224) ? 1 : 0), 1'b0, 1'b0,
              8'(pc + 1));
    start = 1'b0;
    run_alu("wrap", K_ACC, 3'd2, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    imem[0] = ins(K_BZA, 3'd0, 3'd1);
    run_alu("bza32", K_BZA, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd32);

    // STR at 32, reset pulsed mid-MEM
    tick();
    tick();
    chk("str_ex_op", 8'(alu_op), 8'(K_STR));
    tick();
    chk("str_req1", 8'(dmem_req), 8'd1);
    chk("str_dwe1", 8'(dmem_we), 8'd1);
    tick();
    chk("str_req2", 8'(dmem_req), 8'd1);
    chk("str_dwe2", 8'(dmem_we), 8'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("str_rst_req", 8'(dmem_req), 8'd0);
    chk("str_rst_dwe", 8'(dmem_we), 8'd0);
    chk("str_rst_pc", imem_addr, 8'd0);
    chk("str_rst_we", 8'(rf_we), 8'd0);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_req", 8'(dmem_req), 8'd0);
    chk("idle_pc", imem_addr, 8'd0);
    chk("idle_done", 8'(done), 8'd0);

    // Halt at 255 with carry set, then restart
    imem[0]   = ins(K_BZA, 3'd0, 3'd7);
    imem[255] = ins(K_BAD, 3'd1, 3'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_alu("bza224", K_BZA, 3'd0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 8'd224);
    for (int pc = 224; pc < 255; pc++)
      run_alu("fill_c", K_ACI, 3'd7, 3'd7, 1'b1, 1'b0, 1'((pc == 254) ? 1 : 0), 1'b0,
              8'(pc + 1));
    tick();
    tick();
    chk("halt_ex_op", 8'(alu_op), 8'(K_BAD));
    chk("halt_ex_we", 8'(rf_we), 8'd0);
    chk("halt_ex_ci", 8'(alu_ci), 8'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("halt_done", 8'(done), 8'd1);
      chk("halt_pc", imem_addr, 8'd255);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_done", 8'(done), 8'd0);
    chk("restart_pc", imem_addr, 8'd0);
    run_alu("post_halt", K_BZA, 3'd0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
